// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-port data_mem between the core load/store
//             path and a host (loader/testbench) port.
//             - One access granted per cycle. The core has fixed priority.
//             - host_lock blocks the core entirely.
//             - Optional starvation counter forces a host grant after
//               MAX_WAIT consecutive denied host cycles.
//             - Load data is registered and returned one cycle after grant.
//  Build    : define DMEM_ARB_STARVE_EN to compile in the host wait counter
//             and the forced-host rule. Without it the arbiter uses pure
//             fixed priority (lock, then core, then host).
//  Ports    : clk, reset (async, active-low)
//             core_req/we/addr/wdata      -> core_gnt/stall/rvalid/rdata
//             host_req/we/addr/wdata/lock -> host_gnt/rvalid/rdata
//             mem_addr/read/write/wdata   -> data_mem, mem_rdata <- data_mem
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    // core load/store path
    input  logic       core_req,
    input  logic       core_we,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_gnt,
    output logic       core_stall,
    output logic       core_rvalid,
    output logic [7:0] core_rdata,
    // host port
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_lock,
    output logic       host_gnt,
    output logic       host_rvalid,
    output logic [7:0] host_rdata,
    // data_mem side
    output logic [7:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    // Elaboration-time guard on the parameter range (counter is 4 bits).
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_check
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

    logic       w_core_gnt;
    logic       w_host_gnt;
    logic       w_host_force;
    logic       r_core_rvalid;
    logic       r_host_rvalid;
    logic [7:0] r_core_rdata;
    logic [7:0] r_host_rdata;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;

    // Host has waited long enough: it goes ahead of the core this cycle.
    assign w_host_force = host_req && (r_wait_cnt == c_max_wait);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
        end else if (!host_req || w_host_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != c_max_wait) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end
`else
    assign w_host_force = 1'b0;
`endif

    // Grant decode. Gated by reset so nothing reaches memory while the
    // block is held in reset.
    always_comb begin
        w_core_gnt = 1'b0;
        w_host_gnt = 1'b0;
        if (!reset) begin
            w_core_gnt = 1'b0;
            w_host_gnt = 1'b0;
        end else if (host_lock) begin
            w_host_gnt = host_req;
        end else if (w_host_force) begin
            w_host_gnt = 1'b1;
        end else if (core_req) begin
            w_core_gnt = 1'b1;
        end else if (host_req) begin
            w_host_gnt = 1'b1;
        end
    end

    // Memory mux: the granted requester drives address/data, zero when idle.
    always_comb begin
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (w_core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_write = core_we;
            mem_read  = ~core_we;
        end else if (w_host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_write = host_we;
            mem_read  = ~host_we;
        end
    end

    // Read return: capture on a granted load, rvalid pulses for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_core_rdata  <= 8'h00;
            r_host_rdata  <= 8'h00;
        end else begin
            r_core_rvalid <= w_core_gnt & ~core_we;
            r_host_rvalid <= w_host_gnt & ~host_we;
            if (w_core_gnt && !core_we) begin
                r_core_rdata <= mem_rdata;
            end
            if (w_host_gnt && !host_we) begin
                r_host_rdata <= mem_rdata;
            end
        end
    end

    assign core_gnt    = w_core_gnt;
    assign core_stall  = core_req & ~w_core_gnt;
    assign core_rvalid = r_core_rvalid;
    assign core_rdata  = r_core_rdata;
    assign host_gnt    = w_host_gnt;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A behavioural data_mem
//             (combinational read, write on rising edge) sits on the memory
//             port. Directed vector table plus hand sequences for reset,
//             contention, lock and mid-access reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit c_starve = 1'b1;
`else
    localparam bit c_starve = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata;
    logic       core_gnt, core_stall, core_rvalid;
    logic [7:0] core_rdata;
    logic       host_req, host_we, host_lock;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_read, mem_write;

    logic [7:0] r_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural data_mem
    assign mem_rdata = r_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) r_mem[mem_addr] <= mem_wdata;
    end

    typedef struct packed {
        logic       c_req;
        logic       c_we;
        logic [7:0] c_addr;
        logic [7:0] c_wdata;
        logic       h_req;
        logic       h_we;
        logic [7:0] h_addr;
        logic [7:0] h_wdata;
        logic       lock;
    } in_t;

    typedef struct packed {
        logic       cg;
        logic       hg;
        logic       st;
        logic       mw;
        logic       mr;
        logic [7:0] ma;
        logic [7:0] md;
        logic       crv;
        logic [7:0] crd;
        logic       hrv;
        logic [7:0] hrd;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int c_nvec = 15;
    vec_t vecs [c_nvec];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        core_req   = v.c_req;
        core_we    = v.c_we;
        core_addr  = v.c_addr;
        core_wdata = v.c_wdata;
        host_req   = v.h_req;
        host_we    = v.h_we;
        host_addr  = v.h_addr;
        host_wdata = v.h_wdata;
        host_lock  = v.lock;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    out_t act;
    logic exp_h;

    initial begin
        for (int a = 0; a < 256; a++) r_mem[a] = 8'h00;

        // Table: c_req c_we c_addr c_wdata h_req h_we h_addr h_wdata lock |
        //        cg hg st mw mr ma md crv crd hrv hrd
        vecs[0]  = '{'{1'b1,1'b1,8'h10,8'h5A, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h10,8'h5A,1'b0,8'h00,1'b0,8'h00}};
        vecs[1]  = '{'{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h10,8'h00,1'b0,8'h00,1'b0,8'h00}};
        vecs[2]  = '{'{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'h5A,1'b0,8'h00}};
        vecs[3]  = '{'{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'hC3, 1'b0},
                     '{1'b0,1'b1,1'b0,1'b1,1'b0,8'h20,8'hC3,1'b0,8'h5A,1'b0,8'h00}};
        vecs[4]  = '{'{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b0,8'h20,8'h00, 1'b0},
                     '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h10,8'h00,1'b0,8'h5A,1'b0,8'h00}};
        vecs[5]  = '{'{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h00, 1'b0},
                     '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h20,8'h00,1'b1,8'h5A,1'b0,8'h00}};
        vecs[6]  = '{'{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h5A,1'b1,8'hC3}};
        vecs[7]  = '{'{1'b1,1'b1,8'h30,8'h11, 1'b0,1'b0,8'h00,8'h00, 1'b1},
                     '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,8'h5A,1'b0,8'hC3}};
        vecs[8]  = '{'{1'b1,1'b1,8'h30,8'h11, 1'b1,1'b1,8'h30,8'h22, 1'b1},
                     '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h30,8'h22,1'b0,8'h5A,1'b0,8'hC3}};
        vecs[9]  = '{'{1'b1,1'b1,8'h30,8'h11, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h30,8'h11,1'b0,8'h5A,1'b0,8'hC3}};
        vecs[10] = '{'{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h30,8'h00, 1'b0},
                     '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h30,8'h00,1'b0,8'h5A,1'b0,8'hC3}};
        vecs[11] = '{'{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h5A,1'b1,8'h11}};
        vecs[12] = '{'{1'b1,1'b1,8'h40,8'h77, 1'b1,1'b0,8'h40,8'h00, 1'b0},
                     '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h40,8'h77,1'b0,8'h5A,1'b0,8'h11}};
        vecs[13] = '{'{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h40,8'h00, 1'b0},
                     '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h40,8'h00,1'b0,8'h5A,1'b0,8'h11}};
        vecs[14] = '{'{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0},
                     '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h5A,1'b1,8'h77}};

        // ---------------- reset / idle ----------------
        reset = 1'b0;
        drive('{1'b1,1'b1,8'h55,8'h99, 1'b0,1'b0,8'h00,8'h00, 1'b0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_idle", 64'({core_gnt, mem_write, core_rvalid, core_rdata}), 64'(0));
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("release_core_gnt", 64'(core_gnt), 64'(1));
        next_cycle();

        // ---------------- vector table ----------------
        for (int v = 0; v < c_nvec; v++) begin
            drive(vecs[v].i);
            @(negedge clk);
            act = {core_gnt, host_gnt, core_stall, mem_write, mem_read, mem_addr,
                   mem_wdata, core_rvalid, core_rdata, host_rvalid, host_rdata};
            if (act !== vecs[v].o) begin
                n_errors++;
                $display("FAIL vec%0d: got %h expected %h", v, act, vecs[v].o);
            end
            n_checks++;
            next_cycle();
        end

        // ---------------- contention ----------------
        drive('{1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,8'h01,8'h00, 1'b0});
        for (int c = 0; c < 20; c++) begin
            exp_h = c_starve && (c % 5 == 4);
            @(negedge clk);
            chk($sformatf("contend_c%0d", c), 64'({core_gnt, host_gnt}), 64'({~exp_h, exp_h}));
            next_cycle();
        end

        // ---------------- lock ----------------
        for (int c = 0; c < 4; c++) begin
            drive('{1'b1,1'b1,8'h90,8'hEE, 1'b1,1'b1,8'(8'h80 + c),8'(c + 1), 1'b1});
            @(negedge clk);
            chk($sformatf("lock_c%0d", c), 64'({core_stall, host_gnt, core_gnt}), 64'(3'b110));
            next_cycle();
        end
        drive('{1'b1,1'b1,8'h90,8'hEE, 1'b0,1'b0,8'h00,8'h00, 1'b0});
        @(negedge clk);
        chk("unlock_core_gnt", 64'({core_gnt, core_stall}), 64'(2'b10));
        next_cycle();

        // host readback of 0x80..0x83, back-to-back
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive('{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'(8'h80 + c),8'h00, 1'b0});
            else       drive('{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0});
            @(negedge clk);
            if (c > 0)
                chk($sformatf("readback_%0d", c), 64'({host_rvalid, host_rdata}), 64'({1'b1, 8'(c)}));
            next_cycle();
        end

        // ---------------- mid-access reset ----------------
        drive('{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b0});
        @(negedge clk);
        chk("midrst_gnt", 64'(host_gnt), 64'(1));
        reset = 1'b0;
        #1;
        chk("midrst_gnt_drop", 64'(host_gnt), 64'(0));
        next_cycle();
        chk("midrst_rvalid_held", 64'(host_rvalid), 64'(0));
        host_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("midrst_after", 64'({host_rvalid, host_rdata}), 64'(0));
        next_cycle();

        // ---------------- reset clears wait counter ----------------
        drive('{1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,8'h01,8'h00, 1'b0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("pre_rst_c%0d", c), 64'({core_gnt, host_gnt}), 64'(2'b10));
            next_cycle();
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_no_gnt", 64'({core_gnt, host_gnt, mem_read}), 64'(0));
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_h = c_starve && (c == 4);
            @(negedge clk);
            chk($sformatf("post_rst_c%0d", c), 64'({core_gnt, host_gnt}), 64'({~exp_h, exp_h}));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port `data_mem` between the CPU core's load/store path and a host port.
- The host port is used by the testbench or loader to preload operands and read back results.
- Grants at most one access per cycle: core has fixed priority, and host is protected by a starvation counter.
- Sits between the `mem_Address` mux/`DataOut` path in `top` and `data_mem`; read data is registered and returned one cycle after grant.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive denied host cycles before host is forced ahead of core; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core access request; held with address/data until granted
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  8  core address
- `core_wdata`  in  8  core store data
- `core_gnt`  out  1  core access performed this cycle
- `core_stall`  out  1  `core_req & ~core_gnt`; feeds IF halt
- `core_rvalid`  out  1  core load data valid
- `core_rdata`  out  8  core load data
- `host_req`, `host_we`, `host_addr[7:0]`, `host_wdata[7:0]`  in  host equivalents of the core request signals
- `host_lock`  in  1  when high, core is never granted
- `host_gnt`, `host_rvalid`, `host_rdata[7:0]`  out  host equivalents of the core response signals
- `mem_addr`  out  8  to `DataAddress`
- `mem_read`  out  1  to `ReadMem`
- `mem_write`  out  1  to `WriteMem`
- `mem_wdata`  out  8  to `DataIn`
- `mem_rdata`  in  8  from `DataOut`; combinational read of `mem_addr`

## Operation
- Grant is combinational from the current requests and the registered state.
- Priority order:
  1. reset asserted: no grants.
  2. `host_lock` high: host granted if requesting; core never granted.
  3. `wait_cnt == MAX_WAIT` and `host_req`: host granted.
  4. `core_req`: core granted.
  5. `host_req`: host granted.
- At most one of `core_gnt`/`host_gnt` is high in any cycle.
- Mem mux:
  - `mem_addr`/`mem_wdata` come from the granted requester; they are 0 when no grant.
  - `mem_write = gnt & we`.
  - `mem_read = gnt & ~we`.
- Host wait counter `wait_cnt` (4 bits):
  - Increments, saturating at `MAX_WAIT`, each cycle `host_req & ~host_gnt`.
  - Clears on `host_gnt` or `~host_req`.
- Read return:
  - On a granted load, `mem_rdata` is registered into the requester's `rdata` register and its `rvalid` pulses high for exactly the next cycle.
  - `rdata` holds its value until the next load by the same requester.
  - Stores produce no `rvalid`.
- Requester protocol:
  - `req`, `we`, `addr` and `wdata` must stay stable from assertion until the `gnt` cycle.
  - `req` may drop after `gnt`, or stay high for back-to-back accesses (one access per `gnt` cycle).
- `core_stall` is high every cycle the core requests without a grant. The core must not advance PC while `core_stall` is high.

## Timing
- Reset (`reset` low, async) forces:
  - `wait_cnt` = 0
  - `core_rvalid`, `host_rvalid` = 0
  - `core_rdata`, `host_rdata` = 8'h00
  - all gnt/mem outputs = 0
- Outputs return to normal decode on the first edge after deassertion.
- Grant latency: 0 cycles with no contention. Worst-case host latency is `MAX_WAIT` cycles under continuous core traffic.
- Write latency: memory is updated at the rising edge ending the grant cycle.
- Read latency: `rvalid`/`rdata` are valid in the cycle after the grant.
- Simultaneous events:
  - Same-address core store and host load in one cycle cannot both be granted; the loser sees the post-write value on its later grant.
  - If reset asserts mid-access, the access is dropped. A pending `rvalid` is cleared immediately (async), and a write on that edge is not guaranteed.
- `host_lock` change takes effect in the same cycle; there is no state to flush.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - The `wait_cnt` counter and the forced-host rule (priority 3) are compiled in.
- `DMEM_ARB_STARVE_EN` undefined:
  - No counter and pure fixed priority (lock, then core, then host).
  - The host can starve indefinitely under continuous core requests.
  - `MAX_WAIT` is ignored.

## Test plan
- Reset/idle:
  - Stimulus: hold `reset` low 3 cycles with `core_req=1`.
  - Required: `core_gnt=0`, `mem_write=0`, `core_rvalid=0`, `core_rdata=8'h00`; `core_gnt=1` in the first cycle after release.
- Core round-trip:
  - Stimulus: core store 8'h5A to 8'h10, then load 8'h10.
  - Required: `mem_write=1` with `mem_addr=8'h10` in cycle 0; `core_rvalid=1`, `core_rdata=8'h5A` in cycle 2.
- Contention:
  - Stimulus: core and host both request continuously with `MAX_WAIT=4`.
  - Required (starve enabled): core granted 4 cycles, host granted on the 5th, pattern repeats.
  - Required (macro off): host is never granted over 20 cycles.
- Lock:
  - Stimulus: `host_lock=1`, host writes 8'h80..8'h83 with data 1..4 while `core_req=1`.
  - Required: `core_stall=1` for all 4 cycles; core granted the cycle lock drops; host readback returns 1..4.
- Mid-access reset:
  - Stimulus: host load granted, `reset` pulsed low before the next edge.
  - Required: `host_rvalid` stays 0 and `wait_cnt` reads 0 after release.
